// File: rtl/tlb_array_if.sv
// Interface between the MMU/CSR stage and the TLB array.
// Carries the lookup, write, read and INVTLB request/response signals.
interface tlb_array_if #(
    parameter int unsigned TLBIDX_W = 4
);
    logic                srch_valid;
    logic [18:0]         srch_vppn;
    logic                srch_odd;
    logic [9:0]          srch_asid;

    logic                resp_valid;
    logic                resp_found;
    logic [TLBIDX_W-1:0] resp_index;
    logic [19:0]         resp_ppn;
    logic [5:0]          resp_ps;
    logic                resp_v;
    logic                resp_d;
    logic [1:0]          resp_mat;
    logic [1:0]          resp_plv;

    logic                wr_en;
    logic [TLBIDX_W-1:0] wr_index;
    logic [88:0]         wr_entry;

    logic [TLBIDX_W-1:0] rd_index;
    logic [88:0]         rd_entry;

    logic                inv_valid;
    logic [4:0]          inv_op;
    logic [9:0]          inv_asid;
    logic [18:0]         inv_vppn;
    logic                inv_busy;
    logic                inv_done;

    modport master (
        output srch_valid, srch_vppn, srch_odd, srch_asid,
        output wr_en, wr_index, wr_entry, rd_index,
        output inv_valid, inv_op, inv_asid, inv_vppn,
        input  resp_valid, resp_found, resp_index, resp_ppn, resp_ps,
        input  resp_v, resp_d, resp_mat, resp_plv,
        input  rd_entry, inv_busy, inv_done
    );

    modport slave (
        input  srch_valid, srch_vppn, srch_odd, srch_asid,
        input  wr_en, wr_index, wr_entry, rd_index,
        input  inv_valid, inv_op, inv_asid, inv_vppn,
        output resp_valid, resp_found, resp_index, resp_ppn, resp_ps,
        output resp_v, resp_d, resp_mat, resp_plv,
        output rd_entry, inv_busy, inv_done
    );
endinterface

// File: rtl/tlb_array.sv
// Fully associative LoongArch TLB: single-cycle registered lookup, CSR write/read
// ports and a one-entry-per-cycle INVTLB sweep.
module tlb_array #(
    parameter int unsigned TLBNUM = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    tlb_array_if.slave  bus
);
    localparam int unsigned         TLBIDX_W = $clog2(TLBNUM);
    localparam logic [5:0]          PS_HUGE  = 6'd21;
    localparam logic [TLBIDX_W-1:0] LAST_IDX = TLBIDX_W'(TLBNUM - 1);

    typedef struct packed {
        logic        e;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic [18:0] vppn;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        INV_IDLE  = 2'd0,
        INV_SWEEP = 2'd1,
        INV_DONE  = 2'd2
    } inv_state_t;

    tlb_entry_t          entries [TLBNUM];
    tlb_entry_t          wr_data_c;
    inv_state_t          inv_state;
    logic [TLBIDX_W-1:0] inv_ptr;
    logic [4:0]          inv_op_q;
    logic [9:0]          inv_asid_q;
    logic [18:0]         inv_vppn_q;

    assign wr_data_c = tlb_entry_t'(bus.wr_entry);

    // Huge (2 MB) pages ignore the low nine VPPN bits.
    function automatic logic vppn_match(tlb_entry_t ent, logic [18:0] vppn);
        if (ent.ps == PS_HUGE) return ent.vppn[18:9] == vppn[18:9];
        return ent.vppn == vppn;
    endfunction

    function automatic logic inv_hit(tlb_entry_t ent, logic [4:0] op,
                                     logic [9:0] asid, logic [18:0] vppn);
        logic asid_eq;
        logic va_eq;
        asid_eq = (ent.asid == asid);
        va_eq   = vppn_match(ent, vppn);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return ent.g;
            5'd3:       return !ent.g;
            5'd4:       return !ent.g && asid_eq;
            5'd5:       return !ent.g && asid_eq && va_eq;
            5'd6:       return (ent.g || asid_eq) && va_eq;
            default:    return 1'b0;
        endcase
    endfunction

    // Lookup: match every entry, lowest matching index wins.
    logic [TLBNUM-1:0]   hit_c;
    logic                found_c;
    logic [TLBIDX_W-1:0] hit_idx_c;
    tlb_entry_t          sel_c;
    logic                odd_c;

    always_comb begin
        hit_c     = '0;
        found_c   = 1'b0;
        hit_idx_c = '0;
        for (int i = 0; i < int'(TLBNUM); i++) begin
            hit_c[i] = entries[i].e
                     && (entries[i].g || (entries[i].asid == bus.srch_asid))
                     && vppn_match(entries[i], bus.srch_vppn);
        end
        for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                found_c   = 1'b1;
                hit_idx_c = TLBIDX_W'(i);
            end
        end
    end

    assign sel_c = entries[hit_idx_c];
    assign odd_c = (sel_c.ps == PS_HUGE) ? bus.srch_vppn[8] : bus.srch_odd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid <= 1'b0;
            bus.resp_found <= 1'b0;
            bus.resp_index <= '0;
            bus.resp_ppn   <= '0;
            bus.resp_ps    <= '0;
            bus.resp_v     <= 1'b0;
            bus.resp_d     <= 1'b0;
            bus.resp_mat   <= '0;
            bus.resp_plv   <= '0;
        end else begin
            bus.resp_valid <= bus.srch_valid;
            if (bus.srch_valid && found_c) begin
                bus.resp_found <= 1'b1;
                bus.resp_index <= hit_idx_c;
                bus.resp_ppn   <= odd_c ? sel_c.ppn1 : sel_c.ppn0;
                bus.resp_ps    <= sel_c.ps;
                bus.resp_v     <= odd_c ? sel_c.v1   : sel_c.v0;
                bus.resp_d     <= odd_c ? sel_c.d1   : sel_c.d0;
                bus.resp_mat   <= odd_c ? sel_c.mat1 : sel_c.mat0;
                bus.resp_plv   <= odd_c ? sel_c.plv1 : sel_c.plv0;
            end else begin
                bus.resp_found <= 1'b0;
                bus.resp_index <= '0;
                bus.resp_ppn   <= '0;
                bus.resp_ps    <= '0;
                bus.resp_v     <= 1'b0;
                bus.resp_d     <= 1'b0;
                bus.resp_mat   <= '0;
                bus.resp_plv   <= '0;
            end
        end
    end

    // Sweep clear of the entry under the pointer; a same-cycle write to it wins.
    logic clear_c;
    assign clear_c = (inv_state == INV_SWEEP)
                   && inv_hit(entries[inv_ptr], inv_op_q, inv_asid_q, inv_vppn_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(TLBNUM); i++) entries[i] <= '0;
        end else begin
            if (clear_c)    entries[inv_ptr].e     <= 1'b0;
            if (bus.wr_en)  entries[bus.wr_index]  <= wr_data_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.rd_entry <= '0;
        else        bus.rd_entry <= entries[bus.rd_index];
    end

    // INVTLB control: IDLE -> SWEEP -> DONE -> IDLE, illegal ops skip the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_state    <= INV_IDLE;
            inv_ptr      <= '0;
            inv_op_q     <= '0;
            inv_asid_q   <= '0;
            inv_vppn_q   <= '0;
            bus.inv_busy <= 1'b0;
            bus.inv_done <= 1'b0;
        end else begin
            case (inv_state)
                INV_IDLE: begin
                    if (bus.inv_valid) begin
                        bus.inv_busy <= 1'b1;
                        if (bus.inv_op <= 5'd6) begin
                            inv_op_q   <= bus.inv_op;
                            inv_asid_q <= bus.inv_asid;
                            inv_vppn_q <= bus.inv_vppn;
                            inv_ptr    <= '0;
                            inv_state  <= INV_SWEEP;
                        end else begin
                            bus.inv_done <= 1'b1;
                            inv_state    <= INV_DONE;
                        end
                    end
                end
                INV_SWEEP: begin
                    if (inv_ptr == LAST_IDX) begin
                        bus.inv_done <= 1'b1;
                        inv_state    <= INV_DONE;
                    end else begin
                        inv_ptr <= inv_ptr + TLBIDX_W'(1);
                    end
                end
                INV_DONE: begin
                    bus.inv_busy <= 1'b0;
                    bus.inv_done <= 1'b0;
                    inv_state    <= INV_IDLE;
                end
                default: begin
                    bus.inv_busy <= 1'b0;
                    bus.inv_done <= 1'b0;
                    inv_state    <= INV_IDLE;
                end
            endcase
        end
    end
endmodule
